// File: rtl/useq_fifo_arb_pkg.sv
// Shared encodings for the useq message-FIFO arbiter.
package useq_fifo_arb_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic OP_POP  = 1'b0;
   localparam logic OP_PUSH = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2,
      HOLD   = 2'd3
   } state_e;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/useq_rr_pick.sv
// Combinational round-robin picker: nearest requester strictly after 'last' wins.
module useq_rr_pick
   import useq_fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   grant,
   output logic               any_valid
);

   // Scan farthest to nearest so the nearest candidate overwrites the others.
   always_comb begin
      grant     = last;
      any_valid = 1'b0;
      for (int unsigned off = NUM_REQ; off >= 1; off--) begin
         if (req[IDX_W'((32'(last) + off) % NUM_REQ)]) begin
            grant     = IDX_W'((32'(last) + off) % NUM_REQ);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/useq_fifo_arb.sv
// Safe, throttled scheduler of host push/pop pulses onto one useq core FIFO port.
// Optional USEQ_FIFO_ARB_STATS_EN adds saturating ops_count / retry_count outputs.
module useq_fifo_arb
   import useq_fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MAX_BURST   = 4,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         done,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       read_fifo,
   output logic                       write_fifo,
   output logic [DATA_W-1:0]          fifo_in,
   input  logic [DATA_W-1:0]          fifo_out,
   input  logic                       fifo_empty,
   input  logic                       fifo_full
`ifdef USEQ_FIFO_ARB_STATS_EN
   ,
   output logic [15:0]                ops_count,
   output logic [15:0]                retry_count
`endif
);

   localparam int unsigned IDX_W   = idx_width(NUM_REQ);
   localparam int unsigned BURST_W = idx_width(MAX_BURST + 1);
   localparam int unsigned HOLD_W  = idx_width(HOLD_CYCLES);

   state_e               state;
   logic [IDX_W-1:0]     gnt;
   logic [IDX_W-1:0]     rr_last;
   logic [IDX_W-1:0]     pick;
   logic                 op;
   logic [BURST_W-1:0]   burst;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [NUM_REQ-1:0]   skip;
   logic [NUM_REQ-1:0]   base;
   logic [NUM_REQ-1:0]   pref;
   logic [NUM_REQ-1:0]   pick_vec;
   logic                 any_valid;
   logic                 pulse_fire;

   // A requester whose done is showing is finished and must not be re-granted;
   // the one just blocked sits out one arbitration so others keep rotating.
   assign base     = req & ~done;
   assign pref     = base & ~skip;
   assign pick_vec = (pref != '0) ? pref : base;

   useq_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req       (pick_vec),
      .last      (rr_last),
      .grant     (pick),
      .any_valid (any_valid)
   );

   // Gated on live core status so a core-side push/pop after the grant is honoured.
   assign write_fifo = (state == PULSE) && (op == OP_PUSH) && req[gnt] && !fifo_full;
   assign read_fifo  = (state == PULSE) && (op == OP_POP)  && req[gnt] && !fifo_empty;
   assign pulse_fire = write_fifo | read_fifo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         op       <= OP_POP;
         fifo_in  <= '0;
         rd_data  <= '0;
         done     <= '0;
         rr_last  <= IDX_W'(NUM_REQ - 1);
         burst    <= '0;
         hold_cnt <= '0;
         skip     <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               skip <= '0;
               if (any_valid) begin
                  gnt     <= pick;
                  op      <= req_we[pick];
                  fifo_in <= req_wdata[DATA_W*32'(pick) +: DATA_W];
                  state   <= PULSE;
               end else if (req == '0) begin
                  burst <= '0;
               end
            end
            PULSE: begin
               if (pulse_fire) begin
                  state <= SETTLE;
               end else begin
                  skip  <= NUM_REQ'(1) << gnt;
                  state <= IDLE;
               end
            end
            SETTLE: begin
               done[gnt] <= 1'b1;
               if (op == OP_POP) begin
                  rd_data <= fifo_out;
               end
               rr_last <= gnt;
               if ((MAX_BURST != 0) && (burst == BURST_W'(MAX_BURST - 1))) begin
                  burst    <= '0;
                  hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                  state    <= HOLD;
               end else begin
                  if (MAX_BURST != 0) begin
                     burst <= burst + BURST_W'(1);
                  end
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef USEQ_FIFO_ARB_STATS_EN
   logic blocked;

   assign blocked = (state == PULSE) && req[gnt] && !pulse_fire;

   // Saturating activity counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_count   <= '0;
         retry_count <= '0;
      end else begin
         if (pulse_fire && (ops_count != 16'hFFFF)) begin
            ops_count <= ops_count + 16'd1;
         end
         if (blocked && (retry_count != 16'hFFFF)) begin
            retry_count <= retry_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/useq_fifo_arb.md
Name: useq_fifo_arb

Overview:
- Host-side scheduler for one useq core's message FIFO port (read_fifo/write_fifo/fifo_in/fifo_out/fifo_empty/fifo_full).
- Lets NUM_REQ independent requesters push or pop bytes without ever issuing an unsafe pulse (write while full, read while empty).
- Throttles host traffic so the core, which stalls on every host pulse cycle, keeps guaranteed execution cycles.
- Sits between the core and system-side producers/consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, successful pulses before a forced holdoff; 0 disables throttling.
- HOLD_CYCLES, 2, holdoff length in cycles (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester request level
- req_we  in  NUM_REQ  1=push byte, 0=pop byte
- req_wdata  in  8*NUM_REQ  push data, slice i = bits [8i+7:8i]
- done  out  NUM_REQ  one-cycle completion pulse per requester
- rd_data  out  8  popped byte, valid while any done bit is high for a pop
- read_fifo  out  1  to core read_fifo
- write_fifo  out  1  to core write_fifo
- fifo_in  out  8  to core fifo_in
- fifo_out  in  8  from core fifo_out
- fifo_empty  in  1  from core
- fifo_full  in  1  from core

Behaviour:
- Reset values: done=0, rd_data=0, read_fifo=0, write_fifo=0, fifo_in=0, rr pointer=NUM_REQ-1, burst count=0, state=IDLE.
- Requester handshake:
  - Requester raises req[i] with req_we[i] and data, then holds all three stable until done[i].
  - Dropping req[i] before PULSE cancels the request silently.
  - Dropping it after PULSE is illegal and undefined.
- States:
  - IDLE: if any req, round-robin pick starting after the last served index, register grant g, op and data, then go to PULSE.
  - PULSE: one cycle.
    - write_fifo = (op==push) & req[g] & !fifo_full.
    - read_fifo = (op==pop) & req[g] & !fifo_empty.
    - These gates are combinational on the live core status. This covers the core pushing or popping its own FIFO between grant and pulse.
    - fifo_in = registered data.
    - If a pulse fires, go to SETTLE.
    - If not (blocked or cancelled), return to IDLE: no done, rr pointer unchanged, burst count unchanged.
  - SETTLE: fifo_out is valid this cycle; rd_data <= fifo_out (pop only). done[g] asserts the following cycle for exactly one cycle, with rd_data stable in that cycle.
    - Advance rr pointer to g and increment burst count.
    - If burst count reaches MAX_BURST (and MAX_BURST != 0), go to HOLD and clear the count.
    - Otherwise go to IDLE.
  - HOLD: no pulses for HOLD_CYCLES cycles, then IDLE.
- The burst count clears after any IDLE cycle with no request.
- Latency: IDLE grant to done = 3 cycles unblocked. Peak rate 1 op per 3 cycles. The core loses at most 1 of every 3 cycles, plus the holdoff guarantee.
- A blocked requester retries on every arbitration in which it is selected. Other requesters still win in rotation, so a blocked push does not starve pops.
- read_fifo and write_fifo are never high together; never more than one pulse per op.
- Reset in any state: immediate return to reset values, no done, in-flight op lost.

Optional Feature:
- Macro USEQ_FIFO_ARB_STATS_EN.
- Defined: adds outputs ops_count[15:0] (successful pulses) and retry_count[15:0] (blocked PULSE cycles). Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package useq_fifo_arb_pkg holds:
  - state encoding IDLE/PULSE/SETTLE/HOLD;
  - the op encoding localparam (push/pop);
  - the width constant 8.
- Sub-module useq_rr_pick: combinational round-robin picker (req vector, last index -> grant index, any_valid).

Test Plan:
- Requester 1 pushes 8'hA5 on empty FIFO -> write_fifo pulse 1 cycle after grant with fifo_in=8'hA5, done[1] 2 cycles later. Then requester 1 pops -> read_fifo once, rd_data=8'hA5 with done[1].
- fifo_full=1, requester 0 pushes 8'h11 -> no write_fifo, no done. Release full -> one pulse, done[0].
- Requesters 0..3 all pop with FIFO holding 10,20,30,40 -> done order 0,1,2,3, rd_data 10,20,30,40.
- Continuous traffic with MAX_BURST=4, HOLD_CYCLES=2 -> after 4th done, exactly 2 cycles without read_fifo/write_fifo.
- fifo_empty rises in PULSE cycle (core consumed last byte) -> read_fifo stays 0, request retried, no spurious done.
- rst asserted during SETTLE -> next cycle done=0, outputs at reset values. With USEQ_FIFO_ARB_STATS_EN, ops_count=0.
